data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmem_pkg.sv | 54 +++++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/data_mem_unit.sv | 209 ++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit.
//   dmem_size_e  : access size encoding carried on req_size
//   dmem_state_e : control FSM states
//   dmem_req_t   : latched copy of an accepted request
// Helpers compute the byte count of an access and detect misalignment.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } dmem_state_e;

  // Wide enough for the largest wait-state setting (7).
  localparam int unsigned WaitCntW = 3;

  typedef struct packed {
    logic        write;
    dmem_size_e  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Number of bytes touched by an access; the reserved encoding is reported
  // as 4 so the range check stays conservative (it errors anyway).
  function automatic logic [2:0] size_bytes(input dmem_size_e size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(input dmem_size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and an LSB-aligned
// request/response, purely combinational.
//   size_i   : access size
//   uns_i    : zero-extend (1) or sign-extend (0) byte/half loads
//   lane_i   : byte lane of the access inside the word, already aligned
//              to the access size by the caller
//   wdata_i  : LSB-aligned store data
//   rword_i  : memory word read at the access address
//   wword_o  : store data replicated onto the target lanes
//   wstrb_o  : per-lane write enables
//   rdata_o  : LSB-aligned, extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_size_e  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wword_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte   = rword_i[{lane_i, 3'b000} +: 8];
    rhalf   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    wword_o = wdata_i;
    wstrb_o = 4'b0000;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        wword_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << lane_i;
        rdata_o = {{24{~uns_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        wword_o = {2{wdata_i[15:0]}};
        wstrb_o = lane_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = {{16{~uns_i & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        wword_o = wdata_i;
        wstrb_o = 4'b1111;
        rdata_o = rword_i;
      end
      default: begin
        wword_o = wdata_i;
        wstrb_o = 4'b0000;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Single-port byte-addressed data memory with a valid/ready request and
// response handshake and a configurable number of wait states.
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid / req_ready    : request handshake (ready only while idle)
//   req_write                : 1 = store, 0 = load
//   req_size                 : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned             : zero-extend byte/half loads when set
//   req_addr, req_wdata      : byte address, LSB-aligned store data
//   rsp_valid / rsp_ready    : response handshake
//   rsp_rdata                : load result (0 for stores and errors)
//   rsp_err                  : request rejected, no memory side effect
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses; otherwise their low address bits are ignored.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Words  = DEPTH_BYTES / 4;
  localparam int unsigned WordAw = $clog2(Words);
  localparam logic [WaitCntW-1:0] WaitInit =
      (WAIT_STATES == 0) ? '0 : WaitCntW'(WAIT_STATES - 1);

  dmem_state_e         state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  dmem_req_t           req_q, req_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Memory words are held XOR-ed with the low byte of each byte address.
  // An all-zero power-up image therefore reads back as byte i = i mod 256,
  // and reset never touches the array.
  logic [31:0] mem_q [Words] = '{default: '0};

  dmem_req_t         live_req;
  dmem_req_t         cur_req;
  logic              accept;
  logic              enter_resp;
  logic [32:0]       last_addr;
  logic              out_of_range;
  logic              align_bad;
  logic              acc_err;
  logic [1:0]        lane;
  logic [WordAw-1:0] word_idx;
  logic [5:0]        key_hi;
  logic [31:0]       key_word;
  logic [31:0]       rword;
  logic [31:0]       wword;
  logic [3:0]        wstrb;
  logic [31:0]       load_data;
  logic              mem_we;

  always_comb begin
    live_req.write       = req_write;
    live_req.size        = dmem_size_e'(req_size);
    live_req.is_unsigned = req_unsigned;
    live_req.addr        = req_addr;
    live_req.wdata       = req_wdata;
  end

  // With zero wait states the access completes on the acceptance edge, so
  // the decode must look at the live request rather than the latched copy.
  assign cur_req = (state_q == StIdle) ? live_req : req_q;
  assign accept  = req_valid & ready_q;

  assign enter_resp = ((state_q == StIdle) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == StWait) && (wait_cnt_q == '0));

  // Range check uses the address as issued, before any low-bit clearing.
  assign last_addr    = {1'b0, cur_req.addr} + 33'(size_bytes(cur_req.size)) - 33'd1;
  assign out_of_range = (last_addr >= 33'(DEPTH_BYTES));

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_bad = misaligned(cur_req.size, cur_req.addr[1:0]);
`else
  assign align_bad = 1'b0;
`endif

  assign acc_err = (cur_req.size == SZ_RSVD) | out_of_range | align_bad;

  // Lane within the word after dropping the low bits the size ignores.
  always_comb begin
    case (cur_req.size)
      SZ_BYTE: lane = cur_req.addr[1:0];
      SZ_HALF: lane = {cur_req.addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  assign word_idx = cur_req.addr[WordAw+1:2];
  assign key_hi   = cur_req.addr[7:2];
  assign key_word = {key_hi, 2'd3, key_hi, 2'd2, key_hi, 2'd1, key_hi, 2'd0};
  assign rword    = mem_q[word_idx] ^ key_word;

  dmem_lane_align u_lane_align (
    .size_i  (cur_req.size),
    .uns_i   (cur_req.is_unsigned),
    .lane_i  (lane),
    .wdata_i (cur_req.wdata),
    .rword_i (rword),
    .wword_o (wword),
    .wstrb_o (wstrb),
    .rdata_o (load_data)
  );

  assign mem_we = enter_resp & cur_req.write & ~acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) begin
          mem_q[word_idx][8*k +: 8] <= wword[8*k +: 8] ^ key_word[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          req_d = live_req;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d    = StWait;
            wait_cnt_d = WaitInit;
          end
        end
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Response fields are captured once, on the edge that enters RESP.
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || cur_req.write) ? '0 : load_data;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      req_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: one instance with no wait states
// and one with three, driven through a shared transaction task. A byte-level
// reference memory produces the expected response of every request, which
// is queued and compared when the DUT responds.
module tb_data_mem_unit;
  import dmem_pkg::*;

  localparam int unsigned Depth  = 1024;
  localparam int unsigned NumDut = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [NumDut];
  logic        req_valid    [NumDut];
  logic        req_ready    [NumDut];
  logic        req_write    [NumDut];
  logic [1:0]  req_size     [NumDut];
  logic        req_unsigned [NumDut];
  logic [31:0] req_addr     [NumDut];
  logic [31:0] req_wdata    [NumDut];
  logic        rsp_valid    [NumDut];
  logic        rsp_ready    [NumDut];
  logic [31:0] rsp_rdata    [NumDut];
  logic        rsp_err      [NumDut];

  data_mem_unit #(.DEPTH_BYTES(Depth), .WAIT_STATES(0)) u_dut_ws0 (
    .clk          (clk),
    .rst_n        (rst_n[0]),
    .req_valid    (req_valid[0]),
    .req_ready    (req_ready[0]),
    .req_write    (req_write[0]),
    .req_size     (req_size[0]),
    .req_unsigned (req_unsigned[0]),
    .req_addr     (req_addr[0]),
    .req_wdata    (req_wdata[0]),
    .rsp_valid    (rsp_valid[0]),
    .rsp_ready    (rsp_ready[0]),
    .rsp_rdata    (rsp_rdata[0]),
    .rsp_err      (rsp_err[0])
  );

  data_mem_unit #(.DEPTH_BYTES(Depth), .WAIT_STATES(3)) u_dut_ws3 (
    .clk          (clk),
    .rst_n        (rst_n[1]),
    .req_valid    (req_valid[1]),
    .req_ready    (req_ready[1]),
    .req_write    (req_write[1]),
    .req_size     (req_size[1]),
    .req_unsigned (req_unsigned[1]),
    .req_addr     (req_addr[1]),
    .req_wdata    (req_wdata[1]),
    .rsp_valid    (rsp_valid[1]),
    .rsp_ready    (rsp_ready[1]),
    .rsp_rdata    (rsp_rdata[1]),
    .rsp_err      (rsp_err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] model_mem [NumDut][Depth];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  task automatic model_txn(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    int          nb;
    logic [31:0] eff;
    logic [31:0] w;
    logic        bad;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = (sz == 2'b11) || (longint'(addr) + longint'(nb) - 1 >= longint'(Depth));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
    eff = addr;
    if (sz == 2'b01) eff[0] = 1'b0;
    if (sz == 2'b10) eff[1:0] = 2'b00;
    e.err   = bad;
    e.rdata = '0;
    if (!bad) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) model_mem[u][eff + k] = wd[8*k +: 8];
      end else begin
        w = '0;
        for (int k = 0; k < nb; k++) w[8*k +: 8] = model_mem[u][eff + k];
        if (sz == 2'b00 && !uns) w = {{24{w[7]}}, w[7:0]};
        if (sz == 2'b01 && !uns) w = {{16{w[15]}}, w[15:0]};
        e.rdata = w;
      end
    end
  endtask

  task automatic drive_req(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    req_valid[u]    = 1'b1;
    req_write[u]    = wr;
    req_size[u]     = sz;
    req_unsigned[u] = uns;
    req_addr[u]     = addr;
    req_wdata[u]    = wd;
  endtask

  // Issue one request, then hold rsp_ready low for 'hold' extra cycles.
  task automatic run_txn(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         input string tag);
    exp_t e;
    exp_t want;
    int   n;
    model_txn(u, wr, sz, uns, addr, wd, e);
    sb_q.push_back(e);
    @(negedge clk);
    drive_req(u, wr, sz, uns, addr, wd);
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[u] !== 1'b1) begin
      check_eq({tag, " accept"}, 32'(req_ready[u]), 32'd1);
      req_valid[u] = 1'b0;
      sb_q.delete();
      return;
    end
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_eq({tag, " ready low"}, 32'(req_ready[u]), 32'd0);
    end while (rsp_valid[u] !== 1'b1 && n < 20);
    check_eq({tag, " latency"}, 32'(n), 32'(ws_of(u) + 1));
    if (rsp_valid[u] !== 1'b1) begin
      sb_q.delete();
      return;
    end
    want = sb_q.pop_front();
    check_eq({tag, " rdata"}, rsp_rdata[u], want.rdata);
    check_eq({tag, " err"}, 32'(rsp_err[u]), 32'(want.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, " hold valid"}, 32'(rsp_valid[u]), 32'd1);
      check_eq({tag, " hold rdata"}, rsp_rdata[u], want.rdata);
      check_eq({tag, " hold err"}, 32'(rsp_err[u]), 32'(want.err));
      check_eq({tag, " hold ready"}, 32'(req_ready[u]), 32'd0);
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[u] = 1'b0;
    @(negedge clk);
    check_eq({tag, " rsp drop"}, 32'(rsp_valid[u]), 32'd0);
    check_eq({tag, " ready back"}, 32'(req_ready[u]), 32'd1);
  endtask

  // Store accepted, then reset asserted while the access is still waiting.
  task automatic reset_in_wait(input int u);
    int n;
    @(negedge clk);
    drive_req(u, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstwait accept", 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    @(negedge clk);
    rst_n[u] = 1'b0;
    #1;
    check_eq("rstwait valid in rst", 32'(rsp_valid[u]), 32'd0);
    check_eq("rstwait ready in rst", 32'(req_ready[u]), 32'd0);
    @(negedge clk);
    rst_n[u] = 1'b1;
    @(negedge clk);
    check_eq("rstwait valid after", 32'(rsp_valid[u]), 32'd0);
    check_eq("rstwait idle after", 32'(req_ready[u]), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("rstwait no late rsp", 32'(rsp_valid[u]), 32'd0);
  endtask

  initial begin
    int          u;
    int          r;
    logic [31:0] a;
    for (int d = 0; d < NumDut; d++) begin
      for (int i = 0; i < Depth; i++) model_mem[d][i] = 8'(i);
      rst_n[d]        = 1'b0;
      req_valid[d]    = 1'b0;
      req_write[d]    = 1'b0;
      req_size[d]     = 2'b00;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = '0;
      req_wdata[d]    = '0;
      rsp_ready[d]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq("rst req_ready", 32'(req_ready[d]), 32'd0);
      check_eq("rst rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check_eq("rst rsp_rdata", rsp_rdata[d], 32'd0);
      check_eq("rst rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    check_eq("post rst ready0", 32'(req_ready[0]), 32'd1);
    check_eq("post rst ready1", 32'(req_ready[1]), 32'd1);

    run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, "ld_w_10");

    run_txn(0, 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000A5, 0, "st_b_21");
    run_txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 0, "ld_sb_21");
    run_txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 0, "ld_ub_21");
    run_txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 0, "ld_ub_20");
    run_txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, 0, "ld_ub_22");

    run_txn(0, 1'b1, SZ_WORD, 1'b0, Depth - 2, 32'hCAFEF00D, 0, "st_w_top");
    run_txn(0, 1'b0, SZ_HALF, 1'b1, Depth - 2, 32'h0, 0, "ld_uh_top");
    run_txn(0, 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 0, "ld_rsvd");
    run_txn(0, 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h55555555, 0, "st_rsvd");
    run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, "ld_w_10_again");

    run_txn(0, 1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0, 0, "ld_sh_05");

    run_txn(0, 1'b1, SZ_HALF, 1'b0, 32'h32, 32'h0000BEEF, 0, "st_h_32");
    run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 0, "ld_w_30");
    run_txn(0, 1'b1, SZ_WORD, 1'b0, 32'h48, 32'h12345678, 0, "st_w_48");
    run_txn(0, 1'b0, SZ_HALF, 1'b0, 32'h4A, 32'h0, 0, "ld_sh_4a");
    run_txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h4B, 32'h0, 0, "ld_sb_4b");
    run_txn(0, 1'b1, SZ_WORD, 1'b0, 32'h51, 32'h89ABCDEF, 0, "st_w_51");
    run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, 0, "ld_w_50");
    run_txn(0, 1'b0, SZ_BYTE, 1'b0, Depth - 1, 32'h0, 0, "ld_sb_last");
    run_txn(0, 1'b0, SZ_HALF, 1'b1, Depth - 1, 32'h0, 0, "ld_uh_last");

    run_txn(1, 1'b0, SZ_WORD, 1'b0, 32'h84, 32'h0, 5, "ws3_hold");
    reset_in_wait(1);
    run_txn(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 0, "ws3_ld_w_40");
    run_txn(1, 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000007E, 1, "ws3_st_b_41");
    run_txn(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 0, "ws3_ld_w_40b");

    for (int i = 0; i < 40; i++) begin
      u = i % 2;
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, 63));
      else if (r < 9) a = Depth - 8 + 32'($urandom_range(0, 7));
      else a = $urandom;
      run_txn(u, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 16; i += 4) begin
      run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'(i), 32'h0, 0, $sformatf("sweep0_%0d", i));
      run_txn(1, 1'b0, SZ_WORD, 1'b0, 32'(i), 32'h0, 0, $sformatf("sweep1_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
